btb_bimodal_predictor: RTL and testbench

Parametrised, clocked branch target buffer with per-entry N-bit saturating direction counters and tag matching. Replaces the untagged, single-bit, combinational predictor in the fetch stage: fetch issues a PC lookup and receives a registered prediction one cycle later. Execute writes the resolved branch outcome back through a synchronous update port. Supports a single-cycle flush for context switches.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_sat_counter.sv | 16 +
 rtl/btb_bimodal_predictor.sv | 120 ++++++++++++
 tb/tb_btb_bimodal_predictor.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants, default geometry and the saturating-counter rule for the
// bimodal branch target buffer.
package bp_pkg;

  localparam int unsigned ENTRIES_DEF = 16;
  localparam int unsigned TAG_W_DEF   = 8;
  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned CTR_W_DEF   = 2;

  localparam logic [CTR_W_DEF-1:0] CTR_MAX = '1;
  localparam logic [CTR_W_DEF-1:0] CTR_WT  = CTR_W_DEF'(1) << (CTR_W_DEF - 1);
  localparam logic [CTR_W_DEF-1:0] CTR_WNT = CTR_WT - CTR_W_DEF'(1);

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [PC_W_DEF-1:0]   target;
    logic [CTR_W_DEF-1:0]  ctr;
  } bp_entry_t;

  // Width-agnostic saturating step; callers pass their own all-ones ceiling.
  function automatic int unsigned sat_next(input int unsigned ctr,
                                           input logic        taken,
                                           input int unsigned ctr_max);
    if (taken) return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    else       return (ctr == 32'd0)   ? 32'd0   : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one CTR_W-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = CTR_W_DEF
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_ctr_next
);

  localparam int unsigned CTR_CEIL = (32'd1 << CTR_W) - 32'd1;

  assign o_ctr_next = CTR_W'(sat_next(32'(i_ctr), i_taken, CTR_CEIL));

endmodule

// File: rtl/btb_bimodal_predictor.sv
// Tagged BTB with per-entry saturating counters: registered lookup, synchronous
// update, single-cycle flush. Lookups always observe pre-edge state.
module btb_bimodal_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned CTR_W   = CTR_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } slot_t;

  logic [ENTRIES-1:0] r_valid;
  slot_t              r_slot [ENTRIES];

  logic            r_pred_valid;
  logic            r_pred_hit;
  logic            r_pred_taken;
  logic [PC_W-1:0] r_pred_target;

  logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
  logic [TAG_W-1:0] w_lk_tag, w_upd_tag;
  logic             w_lk_hit, w_lk_taken, w_upd_hit;
  logic [PC_W-1:0]  w_lk_seq;
  logic [CTR_W-1:0] w_ctr_next;

  assign w_lk_idx   = lookup_pc[TAG_LO-1:2];
  assign w_lk_tag   = lookup_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign w_upd_idx  = upd_pc[TAG_LO-1:2];
  assign w_upd_tag  = upd_pc[TAG_LO+TAG_W-1:TAG_LO];

  assign w_lk_hit   = r_valid[w_lk_idx] && (r_slot[w_lk_idx].tag == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_slot[w_lk_idx].ctr[CTR_W-1];
  assign w_lk_seq   = lookup_pc + PC_W'(4);
  assign w_upd_hit  = r_valid[w_upd_idx] && (r_slot[w_upd_idx].tag == w_upd_tag);

  // Only the index and tag fields of the update PC steer state.
  if (TAG_LO + TAG_W < PC_W) begin : g_upd_hi
    logic w_unused_upd;
    assign w_unused_upd = ^{upd_pc[PC_W-1:TAG_LO+TAG_W], upd_pc[1:0]};
  end else begin : g_upd_lo
    logic w_unused_upd;
    assign w_unused_upd = ^upd_pc[1:0];
  end

  bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .i_ctr      (r_slot[w_upd_idx].ctr),
    .i_taken    (upd_taken),
    .o_ctr_next (w_ctr_next)
  );

  // Non-valid cycles keep the last hit/taken/target on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid <= lookup_valid;
      if (lookup_valid) begin
        r_pred_hit    <= w_lk_hit;
        r_pred_taken  <= w_lk_taken;
        r_pred_target <= w_lk_taken ? r_slot[w_lk_idx].target : w_lk_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid <= '0;
    end else if (upd_valid && !w_upd_hit && upd_taken) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // NOTE: the slot array has no reset; an entry is only ever read through its
  // valid bit, so clearing r_valid is enough and keeps the array reset-free.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && upd_valid) begin
      if (w_upd_hit) begin
        r_slot[w_upd_idx].ctr <= w_ctr_next;
        if (upd_taken) r_slot[w_upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        r_slot[w_upd_idx].tag    <= w_upd_tag;
        r_slot[w_upd_idx].target <= upd_target;
        r_slot[w_upd_idx].ctr    <= CTR_INIT;
      end
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_hit    = r_pred_hit;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Scoreboard bench: default 16-entry/2-bit instance plus a 64-entry/12-bit-tag/
// 3-bit-counter instance for wrap and wide-counter behaviour.
module tb_btb_bimodal_predictor;

  typedef struct packed {
    logic        v;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } pred_t;

  typedef struct {
    bit          sel;
    logic        lk;
    logic [31:0] lk_pc;
    logic        up;
    logic [31:0] up_pc;
    logic        up_tk;
    logic [31:0] up_tgt;
    logic        fl;
    pred_t       exp;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_lookup_valid, a_upd_valid, a_upd_taken, a_flush;
  logic [31:0] a_lookup_pc, a_upd_pc, a_upd_target;
  logic        a_pred_valid, a_pred_hit, a_pred_taken;
  logic [31:0] a_pred_target;

  logic        b_lookup_valid, b_upd_valid, b_upd_taken, b_flush;
  logic [31:0] b_lookup_pc, b_upd_pc, b_upd_target;
  logic        b_pred_valid, b_pred_hit, b_pred_taken;
  logic [31:0] b_pred_target;

  pred_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  btb_bimodal_predictor u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(a_lookup_valid), .lookup_pc(a_lookup_pc),
    .pred_valid(a_pred_valid), .pred_hit(a_pred_hit),
    .pred_taken(a_pred_taken), .pred_target(a_pred_target),
    .upd_valid(a_upd_valid), .upd_pc(a_upd_pc),
    .upd_taken(a_upd_taken), .upd_target(a_upd_target),
    .flush(a_flush)
  );

  btb_bimodal_predictor #(.ENTRIES(64), .TAG_W(12), .PC_W(32), .CTR_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(b_lookup_valid), .lookup_pc(b_lookup_pc),
    .pred_valid(b_pred_valid), .pred_hit(b_pred_hit),
    .pred_taken(b_pred_taken), .pred_target(b_pred_target),
    .upd_valid(b_upd_valid), .upd_pc(b_upd_pc),
    .upd_taken(b_upd_taken), .upd_target(b_upd_target),
    .flush(b_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic step_t mk(bit sel);
    step_t s;
    s.sel = sel; s.lk = 1'b0; s.lk_pc = '0; s.up = 1'b0; s.up_pc = '0;
    s.up_tk = 1'b0; s.up_tgt = '0; s.fl = 1'b0; s.exp = '0;
    return s;
  endfunction

  function automatic step_t lk(bit sel, logic [31:0] pc, logic hit, logic tk, logic [31:0] tgt);
    step_t s = mk(sel);
    s.lk = 1'b1; s.lk_pc = pc;
    s.exp = {1'b1, hit, tk, tgt};
    return s;
  endfunction

  function automatic step_t up(bit sel, logic [31:0] pc, logic tk, logic [31:0] tgt);
    step_t s = mk(sel);
    s.up = 1'b1; s.up_pc = pc; s.up_tk = tk; s.up_tgt = tgt;
    return s;
  endfunction

  function automatic pred_t observe(bit sel);
    if (sel) return {b_pred_valid, b_pred_hit, b_pred_taken, b_pred_target};
    return {a_pred_valid, a_pred_hit, a_pred_taken, a_pred_target};
  endfunction

  task automatic drive_step(input step_t s);
    a_lookup_valid = s.lk && !s.sel; a_lookup_pc = s.lk_pc;
    a_upd_valid    = s.up && !s.sel; a_upd_pc = s.up_pc;
    a_upd_taken    = s.up_tk;        a_upd_target = s.up_tgt;
    a_flush        = s.fl && !s.sel;
    b_lookup_valid = s.lk && s.sel;  b_lookup_pc = s.lk_pc;
    b_upd_valid    = s.up && s.sel;  b_upd_pc = s.up_pc;
    b_upd_taken    = s.up_tk;        b_upd_target = s.up_tgt;
    b_flush        = s.fl && s.sel;
    if (s.lk) sb.push_back(s.exp);
  endtask

  task automatic test_reset();
    pred_t got;
    step_t s = lk(1'b0, 32'h100, 1'b0, 1'b0, 32'h104);
    drive_step(mk(1'b0));
    rst_n = 1'b0;
    tick();
    s.lk = 1'b0;
    drive_step(s);
    a_lookup_valid = 1'b1;   // lookup while held in reset must not produce a prediction
    tick();
    for (int d = 0; d < 2; d++) begin
      got = observe(d[0]);
      n_checks++;
      if (got !== pred_t'(0)) begin
        n_fail++;
        $display("FAIL reset[dut%0d]: got v=%b hit=%b tk=%b tgt=%h, want all zero",
                 d, got.v, got.hit, got.taken, got.tgt);
      end
    end
    drive_step(mk(1'b0));
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_miss();
    step_t q[$];
    pred_t got, exp;
    q.push_back(lk(1'b0, 32'h100, 1'b0, 1'b0, 32'h104));
    q.push_back(lk(1'b0, 32'h13C, 1'b0, 1'b0, 32'h140));
    foreach (q[i]) begin
      drive_step(q[i]);
      tick();
      if (q[i].lk) begin
        exp = sb.pop_front(); got = observe(q[i].sel); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL miss[%0d]: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
                   i, got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
        end
      end
    end
  endtask

  task automatic test_counter();
    step_t q[$];
    pred_t got, exp;
    q.push_back(up(1'b0, 32'h100, 1'b1, 32'h200));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));   // ctr 2
    repeat (3) q.push_back(up(1'b0, 32'h100, 1'b1, 32'h200));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));   // ctr 3 (held)
    q.push_back(up(1'b0, 32'h100, 1'b0, 32'h0));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));   // ctr 2
    q.push_back(up(1'b0, 32'h100, 1'b0, 32'h0));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b0, 32'h104));   // ctr 1
    q.push_back(up(1'b0, 32'h100, 1'b0, 32'h0));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b0, 32'h104));   // ctr 0
    q.push_back(up(1'b0, 32'h100, 1'b0, 32'h0));
    q.push_back(up(1'b0, 32'h100, 1'b1, 32'h200));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b0, 32'h104));   // held 0, then 1
    q.push_back(up(1'b0, 32'h100, 1'b1, 32'h200));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));   // ctr 2
    q.push_back(up(1'b0, 32'h100, 1'b1, 32'h240));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h240));   // retargeted, ctr 3
    q.push_back(up(1'b0, 32'h100, 1'b1, 32'h200));
    q.push_back(lk(1'b0, 32'h103, 1'b1, 1'b1, 32'h200));   // pc[1:0] ignored
    foreach (q[i]) begin
      drive_step(q[i]);
      tick();
      if (q[i].lk) begin
        exp = sb.pop_front(); got = observe(q[i].sel); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL counter[%0d]: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
                   i, got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
        end
      end
    end
  endtask

  task automatic test_alias();
    step_t q[$];
    pred_t got, exp;
    q.push_back(lk(1'b0, 32'h140, 1'b0, 1'b0, 32'h144));
    q.push_back(up(1'b0, 32'h180, 1'b0, 32'h900));         // miss not-taken: no alloc
    q.push_back(lk(1'b0, 32'h180, 1'b0, 1'b0, 32'h184));
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));
    q.push_back(up(1'b0, 32'h140, 1'b1, 32'h300));         // evicts 0x100
    q.push_back(lk(1'b0, 32'h100, 1'b0, 1'b0, 32'h104));
    q.push_back(lk(1'b0, 32'h142, 1'b1, 1'b1, 32'h300));
    foreach (q[i]) begin
      drive_step(q[i]);
      tick();
      if (q[i].lk) begin
        exp = sb.pop_front(); got = observe(q[i].sel); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL alias[%0d]: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
                   i, got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t q[$];
    step_t s;
    pred_t got, exp;
    s = mk(1'b0); s.fl = 1'b1;
    q.push_back(s);
    s = lk(1'b0, 32'h100, 1'b0, 1'b0, 32'h104);            // sees pre-update state
    s.up = 1'b1; s.up_pc = 32'h100; s.up_tk = 1'b1; s.up_tgt = 32'h200;
    q.push_back(s);
    q.push_back(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));
    foreach (q[i]) begin
      drive_step(q[i]);
      tick();
      if (q[i].lk) begin
        exp = sb.pop_front(); got = observe(q[i].sel); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
                   i, got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
        end
      end
    end
    drive_step(mk(1'b0));
    tick();
    got = observe(1'b0); n_checks++;
    if (got !== {1'b0, 1'b1, 1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL idle_hold: got v=%b hit=%b tk=%b tgt=%h, want v=0 hit=1 tk=1 tgt=00000200",
               got.v, got.hit, got.taken, got.tgt);
    end
  endtask

  task automatic test_flush();
    step_t q[$];
    step_t s;
    pred_t got, exp;
    q.push_back(up(1'b0, 32'h104, 1'b1, 32'h1004));
    q.push_back(up(1'b0, 32'h208, 1'b1, 32'h1008));
    q.push_back(up(1'b0, 32'h30C, 1'b1, 32'h100C));
    q.push_back(lk(1'b0, 32'h208, 1'b1, 1'b1, 32'h1008));
    s = lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200);            // sees pre-flush state
    s.fl = 1'b1;
    s.up = 1'b1; s.up_pc = 32'h410; s.up_tk = 1'b1; s.up_tgt = 32'h500;
    q.push_back(s);
    q.push_back(lk(1'b0, 32'h100, 1'b0, 1'b0, 32'h104));
    q.push_back(lk(1'b0, 32'h104, 1'b0, 1'b0, 32'h108));
    q.push_back(lk(1'b0, 32'h208, 1'b0, 1'b0, 32'h20C));
    q.push_back(lk(1'b0, 32'h30C, 1'b0, 1'b0, 32'h310));
    q.push_back(lk(1'b0, 32'h410, 1'b0, 1'b0, 32'h414));
    foreach (q[i]) begin
      drive_step(q[i]);
      tick();
      if (q[i].lk) begin
        exp = sb.pop_front(); got = observe(q[i].sel); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL flush[%0d]: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
                   i, got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pred_t got, exp;
    step_t s;
    drive_step(up(1'b0, 32'h100, 1'b1, 32'h200));
    tick();
    drive_step(lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200));
    tick();
    exp = sb.pop_front(); got = observe(1'b0); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
               got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
    end
    s = lk(1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
    s.lk = 1'b0;
    drive_step(s);
    a_lookup_valid = 1'b1;   // stream continues into the reset edge
    rst_n = 1'b0;
    tick();
    got = observe(1'b0); n_checks++;
    if (got !== pred_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_assert: got v=%b hit=%b tk=%b tgt=%h, want all zero",
               got.v, got.hit, got.taken, got.tgt);
    end
    drive_step(mk(1'b0));
    rst_n = 1'b1;
    tick();
    got = observe(1'b0); n_checks++;
    if (got !== pred_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_release: got v=%b hit=%b tk=%b tgt=%h, want all zero",
               got.v, got.hit, got.taken, got.tgt);
    end
    drive_step(lk(1'b0, 32'h100, 1'b0, 1'b0, 32'h104));
    tick();
    exp = sb.pop_front(); got = observe(1'b0); n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_after: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
               got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
    end
  endtask

  task automatic test_wide();
    step_t q[$];
    pred_t got, exp;
    q.push_back(lk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0));     // +4 wraps
    q.push_back(up(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40));
    q.push_back(lk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h40));    // ctr 4 (weakly taken)
    q.push_back(up(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
    q.push_back(lk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0));     // ctr 3
    repeat (5) q.push_back(up(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40));
    repeat (4) q.push_back(up(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
    q.push_back(lk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0));     // 7 held, then 3
    q.push_back(up(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40));
    q.push_back(lk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h40));    // ctr 4
    q.push_back(up(1'b1, 32'h100, 1'b1, 32'h700));
    q.push_back(up(1'b1, 32'h140, 1'b1, 32'h800));               // distinct index at 64
    q.push_back(lk(1'b1, 32'h100, 1'b1, 1'b1, 32'h700));
    q.push_back(lk(1'b1, 32'h140, 1'b1, 1'b1, 32'h800));
    q.push_back(lk(1'b1, 32'h1000_0100, 1'b1, 1'b1, 32'h700));   // bits above tag ignored
    foreach (q[i]) begin
      drive_step(q[i]);
      tick();
      if (q[i].lk) begin
        exp = sb.pop_front(); got = observe(q[i].sel); n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL wide[%0d]: got v=%b hit=%b tk=%b tgt=%h, want v=%b hit=%b tk=%b tgt=%h",
                   i, got.v, got.hit, got.taken, got.tgt, exp.v, exp.hit, exp.taken, exp.tgt);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_miss();
    test_counter();
    test_alias();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wide();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
